pipe_decode_stage: RTL and testbench
====================================

# pipe_decode_stage

Registered instruction-decode stage for the MIPS pipeline. It accepts 32-bit instruction words from fetch over a valid/ready handshake, splits them into fields, and extends `imm` and `shamt` to a parametrised datapath width. A two-entry skid buffer lets it present the decoded bundle to execute under full backpressure without a combinational ready path. A flush input supports branch and exception squash.

## Interface
- `XLEN`, default 32: width of the extended `shamt`, `imm_sext` and `imm_zext` outputs; legal range 16..64.
- `PC_W`, default 32: width of the program counter carried alongside each instruction.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: squash all buffered instructions.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept; driven from a register.
- `in_instr` input 32: instruction word.
- `in_pc` input PC_W: PC of `in_instr`.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: execute accepts the bundle.
- `out_op` output 6: instr[31:26].
- `out_rs` output 5: instr[25:21].
- `out_rt` output 5: instr[20:16].
- `out_rd` output 5: instr[15:11].
- `out_shamt` output XLEN: instr[10:6], zero-extended.
- `out_func` output 6: instr[5:0].
- `out_imm_sext` output XLEN: instr[15:0], sign-extended.
- `out_imm_zext` output XLEN: instr[15:0], zero-extended.
- `out_addr` output 26: instr[25:0].
- `out_pc` output PC_W: PC of the bundle.
- `out_illegal` output 1: present only with `DEC_ILLEGAL_CHECK_EN`.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- Field extraction is combinational on `in_instr`. The decoded bundle is captured into the main register (M) or the skid register (S).
- States:
  - EMPTY: M and S invalid.
  - ONE: M valid.
  - TWO: M and S valid.
- EMPTY, input transfer → ONE.
- ONE, input transfer without output transfer → TWO (the new bundle goes to S).
- ONE, output transfer without input transfer → EMPTY.
- ONE, input and output transfer together → ONE (M is loaded with the new bundle).
- TWO, output transfer → ONE (S moves to M). `in_ready` is 0 in TWO, so no input is accepted.
- `in_ready` is registered and equals 1 exactly when the next state is not TWO.
- `out_valid` equals M valid. All `out_*` fields come from M.
- `flush` has priority over every other event. Next state is EMPTY and `in_ready` is 1. An input presented in the same cycle is dropped. An output transfer in the same cycle still completes.
- Contents of M and S do not change while their valid bit is 0. Outputs hold stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle from input transfer to `out_valid` when the stage was EMPTY or ONE-with-drain.
- Throughput is 1 instruction per cycle with `out_ready` held high.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1.
  - All `out_*` fields = 0, including `out_illegal`.
  - State = EMPTY.
- Reset asserted mid-operation discards M and S immediately (asynchronous). The first accept is possible on the first rising edge after `rst_n` rises.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `DEC_ILLEGAL_CHECK_EN` defined:
  - `out_illegal` is registered with the bundle.
  - It is 1 when op is 0x00 and func is outside {0x00,0x02,0x08,0x20,0x21,0x22,0x23,0x24,0x25,0x2A}.
  - It is also 1 when op is outside {0x00,0x02,0x03,0x04,0x05,0x08,0x09,0x0C,0x0D,0x0F,0x23,0x2B}.
  - The bundle still flows; execute handles the exception.
- Not defined: port and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `dec_pkg` holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW);
  - func constants (FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT);
  - the state encoding.
- One combinational sub-module, `dec_fields`, parametrised by XLEN, does field split, extension and the illegal check. Its output bundle feeds both M and S.

## Test plan
- `0x00221820` (add $3,$1,$2) into EMPTY, `out_ready`=1 → next cycle `out_valid`=1 with op 0, rs 1, rt 2, rd 3, shamt 0, func 0x20.
- `0x8C22FFFC` (lw) → `imm_sext` = 0xFFFFFFFC and `imm_zext` = 0x0000FFFC at XLEN=32. At XLEN=64, `imm_sext` = 0xFFFFFFFFFFFFFFFC.
- `0x00011140` (sll) then `0x08000100` (j), with `out_ready` held 0 → state TWO and `in_ready`=0. Raise `out_ready` → shamt 5 appears, then addr 0x100, in order with nothing lost.
- `flush` in TWO with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1. The flushed and presented instructions never appear.
- Assert `rst_n`=0 asynchronously in ONE → `out_valid` drops before the next edge and all fields read 0.
- With `DEC_ILLEGAL_CHECK_EN`: `0xFC000000` → `out_illegal`=1, and `0x00000026` (func 0x26) → `out_illegal`=1. `0x00221820` → `out_illegal`=0.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared decode definitions: MIPS opcode/func constants, skid-buffer state
// encoding and the narrow field bundle. DEC_ILLEGAL_CHECK_EN adds the illegal flag.
package dec_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // EMPTY: nothing held, ONE: main register valid, TWO: main and skid valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } dec_state_e;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] func;
`ifdef DEC_ILLEGAL_CHECK_EN
      logic       illegal;
`endif
   } dec_raw_t;

   function automatic logic is_illegal(input logic [5:0] op, input logic [5:0] func);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_ADDU,
               FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT: bad = 1'b0;
               default:                                bad = 1'b1;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
         OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: bad = 1'b0;
         default:                              bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dec_fields.sv
// Combinational field split and extension of one instruction word.
// DEC_ILLEGAL_CHECK_EN adds the illegal-encoding flag to the bundle.
module dec_fields
   import dec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output dec_raw_t        raw_o,
   output logic [XLEN-1:0] shamt_o,
   output logic [XLEN-1:0] imm_sext_o,
   output logic [XLEN-1:0] imm_zext_o
);

   always_comb begin
      raw_o       = '0;
      raw_o.op    = instr_i[31:26];
      raw_o.rs    = instr_i[25:21];
      raw_o.rt    = instr_i[20:16];
      raw_o.rd    = instr_i[15:11];
      raw_o.shamt = instr_i[10:6];
      raw_o.func  = instr_i[5:0];
`ifdef DEC_ILLEGAL_CHECK_EN
      raw_o.illegal = is_illegal(instr_i[31:26], instr_i[5:0]);
`endif
   end

   // Casts keep XLEN=16 legal, where a zero-width replication would not be
   assign shamt_o    = XLEN'(instr_i[10:6]);
   assign imm_zext_o = XLEN'(instr_i[15:0]);
   assign imm_sext_o = XLEN'($signed(instr_i[15:0]));

endmodule

// File: rtl/pipe_decode_stage.sv
// Registered MIPS decode stage with a two-entry skid buffer (main M, skid S).
// DEC_ILLEGAL_CHECK_EN adds the registered out_illegal port.
module pipe_decode_stage
   import dec_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      out_op,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_shamt,
   output logic [5:0]      out_func,
   output logic [XLEN-1:0] out_imm_sext,
   output logic [XLEN-1:0] out_imm_zext,
   output logic [25:0]     out_addr,
   output logic [PC_W-1:0] out_pc,
`ifdef DEC_ILLEGAL_CHECK_EN
   output logic            out_illegal,
`endif
   output logic [1:0]      dbg_state
);

   dec_state_e      state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            in_xfer, out_xfer;
   logic            load_m_in, load_m_s, load_s_in;

   dec_raw_t        dec_raw;
   logic [XLEN-1:0] dec_shamt, dec_sext, dec_zext;

   dec_raw_t        m_raw_q, s_raw_q;
   logic [XLEN-1:0] m_shamt_q, m_sext_q, m_zext_q;
   logic [XLEN-1:0] s_shamt_q, s_sext_q, s_zext_q;
   logic [PC_W-1:0] m_pc_q, s_pc_q;

   dec_fields #(.XLEN(XLEN)) u_fields (
      .instr_i    (in_instr),
      .raw_o      (dec_raw),
      .shamt_o    (dec_shamt),
      .imm_sext_o (dec_sext),
      .imm_zext_o (dec_zext)
   );

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready comes from a flop, so out_ready never reaches it combinationally.
   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = (state_q != ST_EMPTY) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_ONE;
            ST_ONE: begin
               if (in_xfer && !out_xfer)      state_d = ST_TWO;
               else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready_d = (state_d != ST_TWO);
      load_m_in  = !flush && in_xfer &&
                   ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_xfer));
      load_s_in  = !flush && in_xfer && (state_q == ST_ONE) && !out_xfer;
      load_m_s   = !flush && (state_q == ST_TWO) && out_xfer;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_raw_q   <= '0;
         m_shamt_q <= '0;
         m_sext_q  <= '0;
         m_zext_q  <= '0;
         m_pc_q    <= '0;
      end else if (load_m_in) begin
         m_raw_q   <= dec_raw;
         m_shamt_q <= dec_shamt;
         m_sext_q  <= dec_sext;
         m_zext_q  <= dec_zext;
         m_pc_q    <= in_pc;
      end else if (load_m_s) begin
         m_raw_q   <= s_raw_q;
         m_shamt_q <= s_shamt_q;
         m_sext_q  <= s_sext_q;
         m_zext_q  <= s_zext_q;
         m_pc_q    <= s_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_raw_q   <= '0;
         s_shamt_q <= '0;
         s_sext_q  <= '0;
         s_zext_q  <= '0;
         s_pc_q    <= '0;
      end else if (load_s_in) begin
         s_raw_q   <= dec_raw;
         s_shamt_q <= dec_shamt;
         s_sext_q  <= dec_sext;
         s_zext_q  <= dec_zext;
         s_pc_q    <= in_pc;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = (state_q != ST_EMPTY);
   assign out_op       = m_raw_q.op;
   assign out_rs       = m_raw_q.rs;
   assign out_rt       = m_raw_q.rt;
   assign out_rd       = m_raw_q.rd;
   assign out_shamt    = m_shamt_q;
   assign out_func     = m_raw_q.func;
   assign out_imm_sext = m_sext_q;
   assign out_imm_zext = m_zext_q;
   assign out_addr     = {m_raw_q.rs, m_raw_q.rt, m_raw_q.rd, m_raw_q.shamt, m_raw_q.func};
   assign out_pc       = m_pc_q;
`ifdef DEC_ILLEGAL_CHECK_EN
   assign out_illegal  = m_raw_q.illegal;
`endif
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_decode_stage.sv
// Self-checking bench for pipe_decode_stage: vector table, hand sequences for
// backpressure/flush/async reset, and a randomized run against a queue model.
module tb_pipe_decode_stage;
   import dec_pkg::*;

   localparam int XLEN = 32;
   localparam int PC_W = 32;
   localparam int TW   = 32 + PC_W;
   localparam logic [63:0] XMASK = (XLEN >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                : ((64'd1 << XLEN) - 64'd1);

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, out_ready;
   logic            in_ready, out_valid;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic [5:0]      out_op, out_func;
   logic [4:0]      out_rs, out_rt, out_rd;
   logic [XLEN-1:0] out_shamt, out_imm_sext, out_imm_zext;
   logic [25:0]     out_addr;
   logic [PC_W-1:0] out_pc;
   logic [1:0]      dbg_state;
`ifdef DEC_ILLEGAL_CHECK_EN
   logic            out_illegal;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [TW-1:0] exp_q[$];

   pipe_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_op       (out_op),
      .out_rs       (out_rs),
      .out_rt       (out_rt),
      .out_rd       (out_rd),
      .out_shamt    (out_shamt),
      .out_func     (out_func),
      .out_imm_sext (out_imm_sext),
      .out_imm_zext (out_imm_zext),
      .out_addr     (out_addr),
      .out_pc       (out_pc),
`ifdef DEC_ILLEGAL_CHECK_EN
      .out_illegal  (out_illegal),
`endif
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] fld(input logic [31:0] w, input int lo, input int n);
      return (64'(w) >> lo) & ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] model_sext(input logic [31:0] w);
      longint v;
      v = longint'(fld(w, 0, 16));
      if (v >= 32768) v = v - 65536;
      return 64'(v) & XMASK;
   endfunction

   function automatic logic model_illegal(input logic [31:0] w);
      int ops[12] = '{'h00, 'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0C, 'h0D, 'h0F, 'h23, 'h2B};
      int fns[10] = '{'h00, 'h02, 'h08, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h2A};
      int op, fn;
      logic op_ok, fn_ok;
      op = int'(fld(w, 26, 6));
      fn = int'(fld(w, 0, 6));
      op_ok = 1'b0;
      fn_ok = 1'b0;
      foreach (ops[i]) if (ops[i] == op) op_ok = 1'b1;
      foreach (fns[i]) if (fns[i] == fn) fn_ok = 1'b1;
      return !op_ok || (op == 0 && !fn_ok);
   endfunction

   task automatic check_bundle(input logic [31:0] w, input logic [PC_W-1:0] pc);
      check("mdl.op",    out_op,       fld(w, 26, 6));
      check("mdl.rs",    out_rs,       fld(w, 21, 5));
      check("mdl.rt",    out_rt,       fld(w, 16, 5));
      check("mdl.rd",    out_rd,       fld(w, 11, 5));
      check("mdl.shamt", out_shamt,    fld(w, 6, 5));
      check("mdl.func",  out_func,     fld(w, 0, 6));
      check("mdl.sext",  out_imm_sext, model_sext(w));
      check("mdl.zext",  out_imm_zext, fld(w, 0, 16));
      check("mdl.addr",  out_addr,     fld(w, 0, 26));
      check("mdl.pc",    out_pc,       64'(pc));
`ifdef DEC_ILLEGAL_CHECK_EN
      check("mdl.illegal", out_illegal, 64'(model_illegal(w)));
`endif
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, ".out_valid"}, out_valid, 0);
      check({tag, ".in_ready"},  in_ready,  1);
      check({tag, ".state"},     dbg_state, 64'(ST_EMPTY));
      check({tag, ".fields"},    {out_op, out_rs, out_rt, out_rd, out_func, out_addr}, 0);
      check({tag, ".ext"},       {out_shamt, out_imm_sext, out_imm_zext}, 0);
      check({tag, ".pc"},        out_pc, 0);
`ifdef DEC_ILLEGAL_CHECK_EN
      check({tag, ".illegal"},   out_illegal, 0);
`endif
   endtask

   // ---------------- driver ----------------
   task automatic drive_in(input logic v, input logic [31:0] w, input logic [PC_W-1:0] pc);
      in_valid = v;
      in_instr = w;
      in_pc    = pc;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [5:0]      op;
      logic [4:0]      rs, rt, rd, sh;
      logic [5:0]      fn;
      logic [63:0]     sext;
      logic [15:0]     zext;
      logic [25:0]     addr;
      logic            ill;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{32'h0022_1820, 'h1000, 6'h00, 5'd1, 5'd2,  5'd3,  5'd0,  6'h20,
                  64'h0000_0000_0000_1820, 16'h1820, 26'h022_1820, 1'b0};
      vecs[1] = '{32'h8C22_FFFC, 'h1004, 6'h23, 5'd1, 5'd2,  5'd31, 5'd31, 6'h3C,
                  64'hFFFF_FFFF_FFFF_FFFC, 16'hFFFC, 26'h022_FFFC, 1'b0};
      vecs[2] = '{32'h0001_1140, 'h1008, 6'h00, 5'd0, 5'd1,  5'd2,  5'd5,  6'h00,
                  64'h0000_0000_0000_1140, 16'h1140, 26'h001_1140, 1'b0};
      vecs[3] = '{32'h0800_0100, 'h100C, 6'h02, 5'd0, 5'd0,  5'd0,  5'd4,  6'h00,
                  64'h0000_0000_0000_0100, 16'h0100, 26'h000_0100, 1'b0};
      vecs[4] = '{32'hFC00_0000, 'h1010, 6'h3F, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00,
                  64'h0000_0000_0000_0000, 16'h0000, 26'h000_0000, 1'b1};
      vecs[5] = '{32'h0000_0026, 'h1014, 6'h00, 5'd0, 5'd0,  5'd0,  5'd0,  6'h26,
                  64'h0000_0000_0000_0026, 16'h0026, 26'h000_0026, 1'b1};
      vecs[6] = '{32'h2408_FF9C, 'h1018, 6'h09, 5'd0, 5'd8,  5'd31, 5'd30, 6'h1C,
                  64'hFFFF_FFFF_FFFF_FF9C, 16'hFF9C, 26'h008_FF9C, 1'b0};
      vecs[7] = '{32'h3C01_ABCD, 'h101C, 6'h0F, 5'd0, 5'd1,  5'd21, 5'd15, 6'h0D,
                  64'hFFFF_FFFF_FFFF_ABCD, 16'hABCD, 26'h001_ABCD, 1'b0};
   end

   // ---------------- main sequence ----------------
   initial begin
      logic            exp_ready;
      logic            do_in, do_out;
      logic [31:0]     w;
      logic [PC_W-1:0] pc;

      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive_in(1'b0, '0, '0);

      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("post_reset");

      // table: one instruction at a time into EMPTY, drained immediately
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_in(1'b1, vecs[i].instr, vecs[i].pc);
         @(negedge clk);
         drive_in(1'b0, '0, '0);
         check("vec.valid", out_valid,    1);
         check("vec.op",    out_op,       vecs[i].op);
         check("vec.rs",    out_rs,       vecs[i].rs);
         check("vec.rt",    out_rt,       vecs[i].rt);
         check("vec.rd",    out_rd,       vecs[i].rd);
         check("vec.shamt", out_shamt,    vecs[i].sh);
         check("vec.func",  out_func,     vecs[i].fn);
         check("vec.sext",  out_imm_sext, vecs[i].sext & XMASK);
         check("vec.zext",  out_imm_zext, vecs[i].zext);
         check("vec.addr",  out_addr,     vecs[i].addr);
         check("vec.pc",    out_pc,       vecs[i].pc);
`ifdef DEC_ILLEGAL_CHECK_EN
         check("vec.illegal", out_illegal, vecs[i].ill);
`endif
         @(negedge clk);
         check("vec.drained", out_valid, 0);
      end

      // back-to-back throughput with out_ready high
      drive_in(1'b1, 32'h0022_1820, 'h2000);
      @(negedge clk);
      drive_in(1'b1, 32'h8C22_FFFC, 'h2004);
      check("b2b.first_pc", out_pc, 'h2000);
      check("b2b.ready", in_ready, 1);
      @(negedge clk);
      drive_in(1'b0, '0, '0);
      check("b2b.second_pc", out_pc, 'h2004);
      check("b2b.valid", out_valid, 1);
      @(negedge clk);
      check("b2b.drained", out_valid, 0);

      // fill to TWO under backpressure, then drain in order
      out_ready = 1'b0;
      drive_in(1'b1, 32'h0001_1140, 'h100);
      @(negedge clk);
      check("two.ready_in_one", in_ready, 1);
      drive_in(1'b1, 32'h0800_0100, 'h104);
      @(negedge clk);
      drive_in(1'b0, '0, '0);
      check("two.state", dbg_state, 64'(ST_TWO));
      check("two.in_ready", in_ready, 0);
      check("two.shamt", out_shamt, 5);
      @(negedge clk);
      check("two.hold_shamt", out_shamt, 5);
      check("two.hold_pc", out_pc, 'h100);
      out_ready = 1'b1;
      @(negedge clk);
      check("two.addr", out_addr, 'h100);
      check("two.pc2", out_pc, 'h104);
      check("two.state_one", dbg_state, 64'(ST_ONE));
      check("two.ready_back", in_ready, 1);
      @(negedge clk);
      check("two.drained", out_valid, 0);

      // flush in TWO with a presented instruction
      out_ready = 1'b0;
      drive_in(1'b1, 32'h0022_1820, 'h200);
      @(negedge clk);
      drive_in(1'b1, 32'h8C22_FFFC, 'h204);
      @(negedge clk);
      check("flush2.pre_state", dbg_state, 64'(ST_TWO));
      flush = 1'b1;
      drive_in(1'b1, 32'h3C01_ABCD, 'h208);
      @(negedge clk);
      flush = 1'b0;
      drive_in(1'b0, '0, '0);
      check("flush2.valid", out_valid, 0);
      check("flush2.in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("flush2.stays_empty", out_valid, 0);
      end

      // flush in ONE while in_ready=1: the presented input is still dropped
      out_ready = 1'b0;
      drive_in(1'b1, 32'h0000_0026, 'h300);
      @(negedge clk);
      flush = 1'b1;
      drive_in(1'b1, 32'h2408_FF9C, 'h304);
      @(negedge clk);
      flush = 1'b0;
      drive_in(1'b1, 32'h0800_0100, 'h308);
      check("flush1.valid", out_valid, 0);
      check("flush1.in_ready", in_ready, 1);
      @(negedge clk);
      drive_in(1'b0, '0, '0);
      check("flush1.next_pc", out_pc, 'h308);
      check("flush1.next_addr", out_addr, 'h100);
      out_ready = 1'b1;
      @(negedge clk);
      check("flush1.drained", out_valid, 0);

      // asynchronous reset while in ONE
      out_ready = 1'b0;
      drive_in(1'b1, 32'h0022_1820, 'h400);
      @(negedge clk);
      drive_in(1'b0, '0, '0);
      check("arst.pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("arst");
      @(negedge clk);
      drive_in(1'b1, 32'h8C22_FFFC, 'h404);
      rst_n = 1'b1;
      @(negedge clk);
      drive_in(1'b0, '0, '0);
      check("arst.first_accept", out_valid, 1);
      check("arst.first_pc", out_pc, 'h404);
      out_ready = 1'b1;
      @(negedge clk);
      check("arst.drained", out_valid, 0);

      // randomized run against the queue model
      exp_ready = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check("rnd.out_valid", out_valid, 64'(exp_q.size() > 0));
         check("rnd.in_ready", in_ready, 64'(exp_ready));
         check("rnd.state", dbg_state,
               (exp_q.size() == 0) ? 64'(ST_EMPTY) :
               (exp_q.size() == 1) ? 64'(ST_ONE) : 64'(ST_TWO));
         if (exp_q.size() > 0) check_bundle(exp_q[0][31:0], exp_q[0][TW-1:32]);

         case ($urandom_range(0, 3))
            0:       w = $urandom;
            1:       w = {6'h00, 20'($urandom), 6'($urandom_range(0, 63))};
            default: w = {6'($urandom_range(0, 63)), 26'($urandom)};
         endcase
         pc = PC_W'($urandom);
         drive_in($urandom_range(0, 3) != 0, w, pc);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 31) == 0);

         do_in  = in_valid && exp_ready;
         do_out = (exp_q.size() > 0) && out_ready;
         if (do_out) void'(exp_q.pop_front());
         if (flush) exp_q.delete();
         else if (do_in) exp_q.push_back({pc, w});
         exp_ready = (exp_q.size() < 2);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
